hamm_uart_rx_decoder: RTL and testbench

//  Receive-side end of the Hamming(12,8) UART link. Sits after UART_RX.

---
 rtl/hamm_uart_rx_decoder.sv | 158 +++++++++++++++
 tb/tb_hamm_uart_rx_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamm_uart_rx_decoder.sv
// hamm_uart_rx_decoder: reassembles tagged hi/lo UART bytes into a Hamming(12,8) codeword and decodes it.
// Define HAMM_RX_STATS_EN to build the saturating corrected/uncorrectable counters.
module hamm_uart_rx_decoder #(
   parameter int TIMEOUT_CLKS = 8680,
   parameter int CNT_W        = 16
) (
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   input  logic             i_RX_DV,
   input  logic [7:0]       i_RX_Byte,
   input  logic             i_Clr_Cnt,
   output logic             o_DV,
   output logic [7:0]       o_Byte,
   output logic             o_Corrected,
   output logic             o_Uncorrectable,
   output logic             o_Frame_Err,
   output logic [CNT_W-1:0] o_Corr_Cnt,
   output logic [CNT_W-1:0] o_Uncorr_Cnt
);
   localparam int TW = $clog2(TIMEOUT_CLKS);

   typedef enum logic [1:0] {WAIT_HI, WAIT_LO, DECODE, OUT} state_t;

   state_t        state_q, state_d;
   logic [11:0]   cw_q, cw_d, fix_q, fix_d, fix_c;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    syn_q, syn_d, syn_c;
   logic [7:0]    byte_q, byte_d;
   logic          corr_q, corr_d, uncorr_q, uncorr_d, dv_q, dv_d, ferr_q, ferr_d;
   logic [1:0]    tag;

   assign tag = i_RX_Byte[7:6];

   // The syndrome is the XOR of the position indices of all set bits.
   always_comb begin
      syn_c = '0;
      for (int p = 1; p <= 12; p++) syn_c = syn_c ^ (cw_q[p-1] ? 4'(p) : 4'd0);
      fix_c = cw_q;
      if (syn_c != 4'd0 && syn_c <= 4'd12) fix_c[syn_c - 4'd1] = ~cw_q[syn_c - 4'd1];
   end

   always_comb begin
      state_d  = state_q;
      cw_d     = cw_q;
      timer_d  = timer_q;
      syn_d    = syn_q;
      fix_d    = fix_q;
      byte_d   = byte_q;
      corr_d   = corr_q;
      uncorr_d = uncorr_q;
      dv_d     = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         WAIT_HI: begin
            if (i_RX_DV && tag == 2'b10) begin
               cw_d[11:6] = i_RX_Byte[5:0];
               timer_d    = '0;
               state_d    = WAIT_LO;
            end else if (i_RX_DV) begin
               ferr_d = 1'b1;
            end
         end
         WAIT_LO: begin
            if (i_RX_DV && tag == 2'b01) begin
               cw_d[5:0] = i_RX_Byte[5:0];
               state_d   = DECODE;
            end else if (i_RX_DV && tag == 2'b10) begin
               ferr_d     = 1'b1;
               cw_d[11:6] = i_RX_Byte[5:0];
               timer_d    = '0;
            end else if (i_RX_DV) begin
               ferr_d  = 1'b1;
               state_d = WAIT_HI;
            end else if (timer_q == TW'(TIMEOUT_CLKS - 1)) begin
               ferr_d  = 1'b1;
               state_d = WAIT_HI;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DECODE: begin
            syn_d   = syn_c;
            fix_d   = fix_c;
            ferr_d  = i_RX_DV;
            state_d = OUT;
         end
         default: begin
            dv_d     = 1'b1;
            byte_d   = {fix_q[11], fix_q[10], fix_q[9], fix_q[8], fix_q[6], fix_q[5], fix_q[4], fix_q[2]};
            corr_d   = syn_q != 4'd0 && syn_q <= 4'd12;
            uncorr_d = syn_q >= 4'd13;
            ferr_d   = i_RX_DV;
            state_d  = WAIT_HI;
         end
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q  <= WAIT_HI;
         cw_q     <= '0;
         timer_q  <= '0;
         syn_q    <= '0;
         fix_q    <= '0;
         byte_q   <= '0;
         corr_q   <= 1'b0;
         uncorr_q <= 1'b0;
         dv_q     <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cw_q     <= cw_d;
         timer_q  <= timer_d;
         syn_q    <= syn_d;
         fix_q    <= fix_d;
         byte_q   <= byte_d;
         corr_q   <= corr_d;
         uncorr_q <= uncorr_d;
         dv_q     <= dv_d;
         ferr_q   <= ferr_d;
      end
   end

   assign o_DV            = dv_q;
   assign o_Byte          = byte_q;
   assign o_Corrected     = corr_q;
   assign o_Uncorrectable = uncorr_q;
   assign o_Frame_Err     = ferr_q;

`ifdef HAMM_RX_STATS_EN
   logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;

   // Counters step in the same edge that raises o_DV; a clear overrides the step.
   always_comb begin
      corr_cnt_d   = i_Clr_Cnt ? '0 : corr_cnt_q + CNT_W'(dv_d && corr_d && !(&corr_cnt_q));
      uncorr_cnt_d = i_Clr_Cnt ? '0 : uncorr_cnt_q + CNT_W'(dv_d && uncorr_d && !(&uncorr_cnt_q));
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
      end
   end

   assign o_Corr_Cnt   = corr_cnt_q;
   assign o_Uncorr_Cnt = uncorr_cnt_q;
`else
   logic unused_clr;

   assign unused_clr   = i_Clr_Cnt;
   assign o_Corr_Cnt   = '0;
   assign o_Uncorr_Cnt = '0;
`endif
endmodule

// File: tb/tb_hamm_uart_rx_decoder.sv
// tb_hamm_uart_rx_decoder: scoreboard bench for the Hamming(12,8) UART receive decoder.
module tb_hamm_uart_rx_decoder;
   localparam int CW = 4;
   localparam int TO = 8680;
`ifdef HAMM_RX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]  b;
      logic        c;
      logic        u;
      logic        clr;
      logic [31:0] cyc;
   } exp_t;

   logic          clk = 1'b0, rst_n = 1'b0, rx_dv = 1'b0, clr = 1'b0;
   logic [7:0]    rx_byte = 8'h00;
   logic          o_dv, o_corr, o_uncorr, o_ferr;
   logic [7:0]    o_byte;
   logic [CW-1:0] o_corr_cnt, o_uncorr_cnt;
   logic [CW-1:0] ec = '0, eu = '0;
   exp_t          sb[$];
   exp_t          e;
   int            checks = 0, errors = 0, ferr_cnt = 0, dv_cnt = 0;
   int unsigned   cyc = 0;

   hamm_uart_rx_decoder #(.TIMEOUT_CLKS(TO), .CNT_W(CW)) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte), .i_Clr_Cnt(clr),
      .o_DV(o_dv), .o_Byte(o_byte), .o_Corrected(o_corr), .o_Uncorrectable(o_uncorr),
      .o_Frame_Err(o_ferr), .o_Corr_Cnt(o_corr_cnt), .o_Uncorr_Cnt(o_uncorr_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ext(input logic [11:0] cw);
      return {cw[11], cw[10], cw[9], cw[8], cw[6], cw[5], cw[4], cw[2]};
   endfunction

   function automatic logic [11:0] enc(input logic [7:0] d);
      logic [11:0] cw = '0;
      int dp[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
      logic par;
      for (int i = 0; i < 8; i++) cw[dp[i]-1] = d[i];
      for (int k = 0; k < 4; k++) begin
         par = 1'b0;
         for (int p = 1; p <= 12; p++) if (p[k]) par ^= cw[p-1];
         cw[(1 << k) - 1] = par;
      end
      return cw;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         ec = '0;
         eu = '0;
      end else begin
         if (o_ferr) ferr_cnt++;
         if (o_dv) begin
            dv_cnt++;
            if (sb.size() == 0) check("unexpected_dv", 1, 0);
            else begin
               e = sb.pop_front();
               check("byte", o_byte, e.b);
               check("corrected", o_corr, e.c);
               check("uncorrectable", o_uncorr, e.u);
               check("latency", cyc, e.cyc);
               if (e.clr) begin
                  ec = '0;
                  eu = '0;
               end else begin
                  if (e.c && ec != '1) ec++;
                  if (e.u && eu != '1) eu++;
               end
               check("corr_cnt", o_corr_cnt, STATS ? ec : '0);
               check("uncorr_cnt", o_uncorr_cnt, STATS ? eu : '0);
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_dv = 1'b1;
      rx_byte = b;
      @(negedge clk);
      rx_dv = 1'b0;
   endtask

   task automatic word(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] eb,
                       input logic c, input logic u, input logic cl);
      send(hi);
      @(negedge clk);
      rx_dv = 1'b1;
      rx_byte = lo;
      sb.push_back('{b: eb, c: c, u: u, clr: cl, cyc: cyc + 3});
      @(negedge clk);
      rx_dv = 1'b0;
      @(negedge clk);
      clr = cl;
      @(negedge clk);
      clr = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic word_cw(input logic [11:0] cw, input logic [7:0] eb, input logic c, input logic u,
                          input logic cl);
      word({2'b10, cw[11:6]}, {2'b01, cw[5:0]}, eb, c, u, cl);
   endtask

   initial begin
      int f, d, k, m, p;
      logic [7:0] db;
      logic [11:0] cw;
      repeat (3) @(negedge clk);
      check("rst_dv", o_dv, 0);
      check("rst_byte", o_byte, 0);
      check("rst_flags", {o_corr, o_uncorr, o_ferr}, 0);
      check("rst_cnts", {o_corr_cnt, o_uncorr_cnt}, 0);
      rst_n = 1'b1;
      word(8'hA8, 8'h67, 8'hA5, 1'b0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      check("hold_byte", o_byte, 8'hA5);
      word(8'hA8, 8'h47, 8'hA5, 1'b1, 1'b0, 1'b0);
      word(8'h88, 8'h66, 8'h25, 1'b0, 1'b1, 1'b0);
      f = ferr_cnt;
      d = dv_cnt;
      send(8'h67);
      repeat (3) @(negedge clk);
      check("lone_lo_ferr", ferr_cnt - f, 1);
      check("lone_lo_nodv", dv_cnt - d, 0);
      check("ferr_keeps_byte", o_byte, 8'h25);
      f = ferr_cnt;
      @(negedge clk);
      rx_dv = 1'b1;
      rx_byte = 8'hA8;
      for (k = 1; k <= TO + 20; k++) begin
         @(negedge clk);
         if (k == 1) rx_dv = 1'b0;
         if (o_ferr) break;
      end
      check("timeout_cycles", k, TO + 1);
      word(8'hA8, 8'h67, 8'hA5, 1'b0, 1'b0, 1'b0);
      check("timeout_ferr", ferr_cnt - f, 1);
      f = ferr_cnt;
      send(8'hA8);
      word(8'hA8, 8'h67, 8'hA5, 1'b0, 1'b0, 1'b0);
      check("double_hi_ferr", ferr_cnt - f, 1);
      f = ferr_cnt;
      send(8'hA8);
      @(negedge clk);
      rx_dv = 1'b1;
      rx_byte = 8'h47;
      sb.push_back('{b: 8'hA5, c: 1'b1, u: 1'b0, clr: 1'b0, cyc: cyc + 3});
      @(negedge clk);
      rx_byte = 8'hA8;
      @(negedge clk);
      rx_dv = 1'b0;
      repeat (4) @(negedge clk);
      check("decode_drop_ferr", ferr_cnt - f, 1);
      word(8'h88, 8'h66, 8'h25, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         db = 8'($urandom);
         cw = enc(db);
         m = $urandom_range(0, 2);
         if (m == 0) word_cw(cw, db, 1'b0, 1'b0, 1'b0);
         else if (m == 1) begin
            p = $urandom_range(1, 12);
            cw[p-1] = ~cw[p-1];
            word_cw(cw, db, 1'b1, 1'b0, 1'b0);
         end else begin
            p = $urandom_range(1, 3);
            cw[11] = ~cw[11];
            cw[p-1] = ~cw[p-1];
            word_cw(cw, ext(cw), 1'b0, 1'b1, 1'b0);
         end
      end
      for (int i = 0; i < 16; i++) begin
         cw = enc(8'h3C);
         cw[i % 12] = ~cw[i % 12];
         word_cw(cw, 8'h3C, 1'b1, 1'b0, 1'b0);
      end
      check("corr_saturated", o_corr_cnt, STATS ? 15 : 0);
      word(8'hA8, 8'h47, 8'hA5, 1'b1, 1'b0, 1'b1);
      check("clear_wins", o_corr_cnt, 0);
      word(8'h88, 8'h66, 8'h25, 1'b0, 1'b1, 1'b0);
      send(8'hA8);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_dv", o_dv, 0);
      check("midrst_byte", o_byte, 0);
      check("midrst_flags", {o_corr, o_uncorr, o_ferr}, 0);
      check("midrst_cnts", {o_corr_cnt, o_uncorr_cnt}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      f = ferr_cnt;
      d = dv_cnt;
      send(8'h67);
      repeat (4) @(negedge clk);
      check("post_rst_ferr", ferr_cnt - f, 1);
      check("post_rst_nodv", dv_cnt - d, 0);
      word(8'hA8, 8'h47, 8'hA5, 1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
